// File: rtl/wb_commit.sv
// wb_commit: write-back end of the pipeline.
//   Latches the MEM-stage result bundle into the MEM/WB register under stall
//   control. Drives the GPR write port and commits HI/LO one stage later.
//   Forwards resolved HI/LO to EX and counts committed writes for debug.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   stall[5:0]      - stall vector; [4] MEM stalled, [5] WB stalled
//   mem_*           - result bundle from MEM
//   wb_wd/wreg/wdata - GPR file write port (registered bundle)
//   hi_o, lo_o      - architectural HI/LO
//   ex_hi, ex_lo    - forwarded HI/LO for MFHI/MFLO in EX
//   gpr_commits, hilo_commits - wrapping commit counters
module wb_commit #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall,
    input  logic [AW-1:0] mem_wd,
    input  logic          mem_wreg,
    input  logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_hi,
    input  logic [DW-1:0] mem_lo,
    input  logic          mem_whilo,
    output logic [AW-1:0] wb_wd,
    output logic          wb_wreg,
    output logic [DW-1:0] wb_wdata,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic [DW-1:0] ex_hi,
    output logic [DW-1:0] ex_lo,
    output logic [CW-1:0] gpr_commits,
    output logic [CW-1:0] hilo_commits
);

    logic [AW-1:0] wd_q, wd_d;
    logic          wreg_q, wreg_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] whi_q, whi_d;
    logic [DW-1:0] wlo_q, wlo_d;
    logic          whilo_q, whilo_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [CW-1:0] gpr_cnt_q, gpr_cnt_d;
    logic [CW-1:0] hilo_cnt_q, hilo_cnt_d;

    // MEM/WB latch: bubble when MEM stalls but WB moves on, otherwise load or hold.
    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        whi_d   = whi_q;
        wlo_d   = wlo_q;
        whilo_d = whilo_q;
        if (stall[4] && !stall[5]) begin
            wd_d    = '0;
            wreg_d  = 1'b0;
            wdata_d = '0;
            whi_d   = '0;
            wlo_d   = '0;
            whilo_d = 1'b0;
        end else if (!stall[4]) begin
            wd_d    = mem_wd;
            wreg_d  = mem_wreg;
            wdata_d = mem_wdata;
            whi_d   = mem_hi;
            wlo_d   = mem_lo;
            whilo_d = mem_whilo;
        end
    end

    // HI/LO commit is deliberately not stall-gated: a held bundle rewrites the
    // same values, which is harmless.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (whilo_q) begin
            hi_d = whi_q;
            lo_d = wlo_q;
        end
    end

    always_comb begin
        gpr_cnt_d  = gpr_cnt_q;
        hilo_cnt_d = hilo_cnt_q;
        if (wreg_q && !stall[5]) begin
            gpr_cnt_d = gpr_cnt_q + CW'(1);
        end
        if (whilo_q && !stall[5]) begin
            hilo_cnt_d = hilo_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            wdata_q    <= '0;
            whi_q      <= '0;
            wlo_q      <= '0;
            whilo_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            gpr_cnt_q  <= '0;
            hilo_cnt_q <= '0;
        end else begin
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            whi_q      <= whi_d;
            wlo_q      <= wlo_d;
            whilo_q    <= whilo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            gpr_cnt_q  <= gpr_cnt_d;
            hilo_cnt_q <= hilo_cnt_d;
        end
    end

    // Forwarding: youngest producer wins; HI and LO always travel as a pair.
    always_comb begin
        ex_hi = hi_q;
        ex_lo = lo_q;
        if (rst) begin
            ex_hi = '0;
            ex_lo = '0;
        end else if (mem_whilo) begin
            ex_hi = mem_hi;
            ex_lo = mem_lo;
        end else if (whilo_q) begin
            ex_hi = whi_q;
            ex_lo = wlo_q;
        end
    end

    assign wb_wd        = wd_q;
    assign wb_wreg      = wreg_q;
    assign wb_wdata     = wdata_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign gpr_commits  = gpr_cnt_q;
    assign hilo_commits = hilo_cnt_q;

endmodule

// File: tb/tb_wb_commit.sv
module tb_wb_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo;

    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata, hi_o, lo_o, ex_hi, ex_lo, gpr_commits, hilo_commits;

    logic [4:0]  s_wd;
    logic        s_wreg;
    logic [31:0] s_wdata, s_hi, s_lo, s_ex_hi, s_ex_lo;
    logic [3:0]  s_gpr, s_hilo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_commit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .hi_o(hi_o), .lo_o(lo_o), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .gpr_commits(gpr_commits), .hilo_commits(hilo_commits)
    );

    // Narrow-counter build for the wrap check; shares stimulus with dut.
    wb_commit #(.DW(32), .AW(5), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .wb_wd(s_wd), .wb_wreg(s_wreg), .wb_wdata(s_wdata),
        .hi_o(s_hi), .lo_o(s_lo), .ex_hi(s_ex_hi), .ex_lo(s_ex_lo),
        .gpr_commits(s_gpr), .hilo_commits(s_hilo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with busy inputs
        rst = 1'b1; stall = 6'b0;
        mem_wd = 5'd31; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_BEEF;
        mem_hi = 32'h1111_1111; mem_lo = 32'h2222_2222; mem_whilo = 1'b1;
        step();
        chk("rst_wd", 32'(wb_wd), 32'd0);
        chk("rst_wreg", 32'(wb_wreg), 32'd0);
        chk("rst_wdata", wb_wdata, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        chk("rst_ex_hi", ex_hi, 32'd0);
        chk("rst_ex_lo", ex_lo, 32'd0);
        chk("rst_gpr", gpr_commits, 32'd0);
        chk("rst_hilo", hilo_commits, 32'd0);
        step();

        // First GPR write
        rst = 1'b0;
        mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h1234; mem_whilo = 1'b0;
        step();
        chk("gpr_wd", 32'(wb_wd), 32'd3);
        chk("gpr_wreg", 32'(wb_wreg), 32'd1);
        chk("gpr_wdata", wb_wdata, 32'h1234);
        chk("gpr_cnt_early", gpr_commits, 32'd0);
        mem_wreg = 1'b0;
        step();
        chk("gpr_cnt_1", gpr_commits, 32'd1);

        // HI/LO path
        mem_whilo = 1'b1; mem_hi = 32'hAAAA_0000; mem_lo = 32'h0000_BBBB;
        #1;
        chk("fwd_mem_hi", ex_hi, 32'hAAAA_0000);
        chk("fwd_mem_lo", ex_lo, 32'h0000_BBBB);
        step();
        mem_whilo = 1'b0; mem_hi = 32'h0; mem_lo = 32'h0;
        #1;
        chk("fwd_wb_hi", ex_hi, 32'hAAAA_0000);
        chk("hi_not_yet", hi_o, 32'd0);
        step();
        chk("hi_commit", hi_o, 32'hAAAA_0000);
        chk("lo_commit", lo_o, 32'h0000_BBBB);
        chk("hilo_cnt_1", hilo_commits, 32'd1);
        chk("fwd_arch_lo", ex_lo, 32'h0000_BBBB);

        // Forwarding priority MEM over WB
        mem_whilo = 1'b1; mem_hi = 32'd1; mem_lo = 32'd10;
        step();
        mem_hi = 32'd2; mem_lo = 32'd20;
        #1;
        chk("prio_mem_hi", ex_hi, 32'd2);
        chk("prio_mem_lo", ex_lo, 32'd20);
        mem_whilo = 1'b0;
        #1;
        chk("prio_wb_hi", ex_hi, 32'd1);
        chk("prio_wb_lo", ex_lo, 32'd10);
        step();
        chk("prio_hi_o", hi_o, 32'd1);
        chk("hilo_cnt_2", hilo_commits, 32'd2);

        // Stall bubble
        mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h99;
        step();
        chk("pre_bubble_wreg", 32'(wb_wreg), 32'd1);
        stall = 6'b010000; mem_wd = 5'd10; mem_wdata = 32'hAB;
        step();
        chk("bubble_wreg", 32'(wb_wreg), 32'd0);
        chk("bubble_wd", 32'(wb_wd), 32'd0);
        chk("bubble_wdata", wb_wdata, 32'd0);
        chk("bubble_cnt_a", gpr_commits, 32'd2);
        step();
        chk("bubble_cnt_b", gpr_commits, 32'd2);

        // Stall hold
        stall = 6'b0; mem_wd = 5'd7; mem_wdata = 32'h55;
        step();
        chk("hold_load_wd", 32'(wb_wd), 32'd7);
        stall = 6'b110000; mem_wd = 5'd8; mem_wdata = 32'h66;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_wd", 32'(wb_wd), 32'd7);
            chk("hold_wdata", wb_wdata, 32'h55);
            chk("hold_gpr", gpr_commits, 32'd2);
            chk("hold_hilo", hilo_commits, 32'd2);
        end
        stall = 6'b0;
        step();
        chk("release_wd", 32'(wb_wd), 32'd8);
        chk("release_wdata", wb_wdata, 32'h66);
        chk("release_gpr", gpr_commits, 32'd3);
        mem_wreg = 1'b0;
        step();
        chk("release_gpr2", gpr_commits, 32'd4);

        // Reset during a held stall
        mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h55;
        step();
        chk("pre_rst_wd", 32'(wb_wd), 32'd7);
        stall = 6'b110000; rst = 1'b1;
        step();
        chk("stall_rst_wd", 32'(wb_wd), 32'd0);
        chk("stall_rst_wreg", 32'(wb_wreg), 32'd0);
        chk("stall_rst_wdata", wb_wdata, 32'd0);
        chk("stall_rst_hi", hi_o, 32'd0);
        chk("stall_rst_gpr", gpr_commits, 32'd0);
        chk("stall_rst_gpr4", 32'(s_gpr), 32'd0);

        // Counter wrap on the 4-bit build: 16 commits bring it back to 0
        rst = 1'b0; stall = 6'b0; mem_wreg = 1'b1;
        step();
        chk("wrap_start", 32'(s_gpr), 32'd0);
        for (int i = 0; i < 15; i++) step();
        chk("wrap_15", 32'(s_gpr), 32'd15);
        step();
        chk("wrap_0", 32'(s_gpr), 32'd0);
        chk("nowrap_16", gpr_commits, 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
